// File: rtl/fpu_pkg.sv
`default_nettype none
// =============================================================================
// Module      : fpu_pkg
// Description : Shared widths, bias and result-class encoding for the FPU
//               exponent update path.
// Revision    : 1.0  initial release
// =============================================================================
package fpu_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 24;
    localparam int EXP_BIAS  = (1 << (EXP_W_DEF - 1)) - 1;

    // Two extra bits keep the adjusted exponent signed and free of wrap-around.
    function automatic int ext_width(input int exp_w);
        return exp_w + 2;
    endfunction

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        OVF  = 2'd1,
        UNF  = 2'd2,
        NORM = 2'd3
    } exp_class_e;

endpackage
`default_nettype wire

// File: rtl/exp_classify.sv
`default_nettype none
// =============================================================================
// Module      : exp_classify
// Description : Combinational classification of the adjusted exponent into
//               zero / overflow / underflow / normal result fields.
// Revision    : 1.0  initial release
// =============================================================================
module exp_classify
    import fpu_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    parameter int SUM_W = MAN_W + 3,
    parameter int EXT_W = ext_width(EXP_W)
) (
    input  logic signed [EXT_W-1:0] i_e,
    input  logic        [SUM_W-1:0] i_sum,
    input  logic        [MAN_W-1:0] i_man,
    output logic        [EXP_W-1:0] o_exp,
    output logic        [MAN_W-1:0] o_man,
    output logic                    o_max_exp,
    output logic                    o_zero,
    output logic                    o_underflow,
    output logic        [EXT_W-1:0] o_excess
);

    localparam logic signed [EXT_W-1:0] c_ovf_thresh = $signed(EXT_W'({EXP_W{1'b1}}));
    localparam logic        [EXT_W-1:0] c_one        = EXT_W'(1);

    exp_class_e w_class;

    always_comb begin
        if (i_sum == '0)
            w_class = ZERO;
        else if (i_e >= c_ovf_thresh)
            w_class = OVF;
        else if (i_e[EXT_W-1] || (i_e == '0))
            w_class = UNF;
        else
            w_class = NORM;
    end

    always_comb begin
        o_exp       = '0;
        o_man       = i_man;
        o_max_exp   = 1'b0;
        o_zero      = 1'b0;
        o_underflow = 1'b0;
        o_excess    = '0;
        case (w_class)
            ZERO: o_zero = 1'b1;
            OVF: begin
                o_exp     = '1;
                o_max_exp = 1'b1;
                o_man     = '0;
            end
            UNF: begin
                o_underflow = 1'b1;
                o_excess    = c_one - i_e;
            end
            NORM:    o_exp = i_e[EXP_W-1:0];
            default: o_exp = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/exp_update_pipe.sv
`default_nettype none
// =============================================================================
// Module      : exp_update_pipe
// Description : Two-stage valid/ready pipeline that applies normalisation and
//               rounding adjustments to the exponent and classifies the result.
//               Optional sticky overflow/underflow bits: EXP_UPD_STICKY_EN.
// Revision    : 1.0  initial release
// =============================================================================
module exp_update_pipe
    import fpu_pkg::*;
#(
    parameter int  EXP_W = EXP_W_DEF,
    parameter int  MAN_W = MAN_W_DEF,
    parameter int  SUM_W = MAN_W + 3,
    parameter int  SHL_W = 5,
    localparam int EXT_W = ext_width(EXP_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_in,
    input  logic             ovf,
    input  logic             ovf_rnd,
    input  logic             one_shift_left,
    input  logic [SHL_W-1:0] massive_shift_left,
    input  logic [SUM_W-1:0] sum,
    input  logic [MAN_W-1:0] man_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] man_out,
    output logic             max_exp_flag,
    output logic             zero_flag,
    output logic             underflow_flag,
`ifdef EXP_UPD_STICKY_EN
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic             sticky_unf,
`endif
    output logic [EXT_W-1:0] excess_shift
);

    logic                    r_s1_valid;
    logic signed [EXT_W-1:0] r_s1_e;
    logic        [SUM_W-1:0] r_s1_sum;
    logic        [MAN_W-1:0] r_s1_man;

    logic                    r_s2_valid;
    logic        [EXP_W-1:0] r_exp_out;
    logic        [MAN_W-1:0] r_man_out;
    logic                    r_max_exp;
    logic                    r_zero;
    logic                    r_underflow;
    logic        [EXT_W-1:0] r_excess;

    logic signed [EXT_W-1:0] w_e;
    logic                    w_s2_adv;
    logic                    w_s1_adv;
    logic        [EXP_W-1:0] w_exp;
    logic        [MAN_W-1:0] w_man;
    logic                    w_max_exp;
    logic                    w_zero;
    logic                    w_underflow;
    logic        [EXT_W-1:0] w_excess;

    assign w_e = $signed(EXT_W'(exp_in) + EXT_W'(ovf) + EXT_W'(ovf_rnd)
                       - EXT_W'(one_shift_left) - EXT_W'(massive_shift_left));

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = r_s1_valid && w_s2_adv;
    assign in_ready = !r_s1_valid || w_s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_e     <= '0;
            r_s1_sum   <= '0;
            r_s1_man   <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_e   <= w_e;
                r_s1_sum <= sum;
                r_s1_man <= man_in;
            end
        end
    end

    exp_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .SUM_W (SUM_W),
        .EXT_W (EXT_W)
    ) u_classify (
        .i_e         (r_s1_e),
        .i_sum       (r_s1_sum),
        .i_man       (r_s1_man),
        .o_exp       (w_exp),
        .o_man       (w_man),
        .o_max_exp   (w_max_exp),
        .o_zero      (w_zero),
        .o_underflow (w_underflow),
        .o_excess    (w_excess)
    );

    // Output fields only change when a new result lands, so they hold under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_exp_out   <= '0;
            r_man_out   <= '0;
            r_max_exp   <= 1'b0;
            r_zero      <= 1'b0;
            r_underflow <= 1'b0;
            r_excess    <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_exp_out   <= w_exp;
                r_man_out   <= w_man;
                r_max_exp   <= w_max_exp;
                r_zero      <= w_zero;
                r_underflow <= w_underflow;
                r_excess    <= w_excess;
            end
        end
    end

    assign out_valid      = r_s2_valid;
    assign exp_out        = r_exp_out;
    assign man_out        = r_man_out;
    assign max_exp_flag   = r_max_exp;
    assign zero_flag      = r_zero;
    assign underflow_flag = r_underflow;
    assign excess_shift   = r_excess;

`ifdef EXP_UPD_STICKY_EN
    logic w_xfer;
    logic r_sticky_ovf;
    logic r_sticky_unf;

    assign w_xfer = r_s2_valid && out_ready;

    // A flagged transfer outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_ovf <= 1'b0;
            r_sticky_unf <= 1'b0;
        end else begin
            if (w_xfer && r_max_exp)
                r_sticky_ovf <= 1'b1;
            else if (clr_sticky)
                r_sticky_ovf <= 1'b0;
            if (w_xfer && r_underflow)
                r_sticky_unf <= 1'b1;
            else if (clr_sticky)
                r_sticky_unf <= 1'b0;
        end
    end

    assign sticky_ovf = r_sticky_ovf;
    assign sticky_unf = r_sticky_unf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exp_update_pipe.sv
`default_nettype none
// =============================================================================
// Module      : tb_exp_update_pipe
// Description : Randomised and directed bench for exp_update_pipe against an
//               arithmetic reference model.
// Revision    : 1.0  initial release
// =============================================================================
module tb_exp_update_pipe;

    localparam int EXP_W = 8;
    localparam int MAN_W = 24;
    localparam int SUM_W = MAN_W + 3;
    localparam int SHL_W = 5;
    localparam int EXT_W = EXP_W + 2;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             mx;
        logic             z;
        logic             u;
        logic [EXT_W-1:0] exc;
    } res_t;

    typedef struct {
        int ei; int o; int r; int s; int m; int sm; int mn;
        int ee; int em; int mx; int z; int u; int exc;
    } dvec_t;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] exp_in;
    logic             ovf;
    logic             ovf_rnd;
    logic             one_shift_left;
    logic [SHL_W-1:0] massive_shift_left;
    logic [SUM_W-1:0] sum;
    logic [MAN_W-1:0] man_in;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] exp_out;
    logic [MAN_W-1:0] man_out;
    logic             max_exp_flag;
    logic             zero_flag;
    logic             underflow_flag;
    logic [EXT_W-1:0] excess_shift;
`ifdef EXP_UPD_STICKY_EN
    logic             clr_sticky;
    logic             sticky_ovf;
    logic             sticky_unf;
    bit               m_sov;
    bit               m_sunf;
`endif

    res_t pend_q[$];
    res_t obs_q[$];
    res_t ref_q[$];
    int   spurious;
    int   vectors;
    int   miscompares;
    bit   last_acc;

    exp_update_pipe #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .SUM_W (SUM_W),
        .SHL_W (SHL_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .exp_in             (exp_in),
        .ovf                (ovf),
        .ovf_rnd            (ovf_rnd),
        .one_shift_left     (one_shift_left),
        .massive_shift_left (massive_shift_left),
        .sum                (sum),
        .man_in             (man_in),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .exp_out            (exp_out),
        .man_out            (man_out),
        .max_exp_flag       (max_exp_flag),
        .zero_flag          (zero_flag),
        .underflow_flag     (underflow_flag),
`ifdef EXP_UPD_STICKY_EN
        .clr_sticky         (clr_sticky),
        .sticky_ovf         (sticky_ovf),
        .sticky_unf         (sticky_unf),
`endif
        .excess_shift       (excess_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic res_t ref_model(int ei, int o, int r, int s, int m,
                                       logic [SUM_W-1:0] sm, logic [MAN_W-1:0] mn);
        int   e;
        res_t x;
        e     = ei + o + r - s - m;
        x     = '0;
        x.man = mn;
        if (sm == '0) begin
            x.z = 1'b1;
        end else if (e >= (1 << EXP_W) - 1) begin
            x.exp = '1;
            x.mx  = 1'b1;
            x.man = '0;
        end else if (e <= 0) begin
            x.u   = 1'b1;
            x.exc = EXT_W'(1 - e);
        end else begin
            x.exp = EXP_W'(e);
        end
        return x;
    endfunction

    function automatic res_t cur_out();
        res_t x;
        x.exp = exp_out;
        x.man = man_out;
        x.mx  = max_exp_flag;
        x.z   = zero_flag;
        x.u   = underflow_flag;
        x.exc = excess_shift;
        return x;
    endfunction

    function automatic res_t mk_res(dvec_t d);
        res_t x;
        x.exp = EXP_W'(d.ee);
        x.man = MAN_W'(d.em);
        x.mx  = d.mx[0];
        x.z   = d.z[0];
        x.u   = d.u[0];
        x.exc = EXT_W'(d.exc);
        return x;
    endfunction

    // One clock: record transfers at the negative edge, then advance past posedge.
    task automatic step();
        res_t rr;
`ifdef EXP_UPD_STICKY_EN
        bit xo;
        bit xu;
        xo = 1'b0;
        xu = 1'b0;
`endif
        @(negedge clk);
        if (out_valid && out_ready) begin
            obs_q.push_back(cur_out());
            if (pend_q.size() > 0) begin
                rr = pend_q.pop_front();
                ref_q.push_back(rr);
`ifdef EXP_UPD_STICKY_EN
                xo = rr.mx;
                xu = rr.u;
`endif
            end else begin
                spurious++;
            end
        end
`ifdef EXP_UPD_STICKY_EN
        if (xo) m_sov = 1'b1; else if (clr_sticky) m_sov = 1'b0;
        if (xu) m_sunf = 1'b1; else if (clr_sticky) m_sunf = 1'b0;
`endif
        last_acc = in_valid && in_ready && !flush && !rst;
        if (last_acc)
            pend_q.push_back(ref_model(int'(exp_in), int'(ovf), int'(ovf_rnd),
                                       int'(one_shift_left), int'(massive_shift_left),
                                       sum, man_in));
        if (flush)
            pend_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand_inputs();
        case ($urandom_range(0, 3))
            0:       exp_in = EXP_W'($urandom_range(0, 8));
            1:       exp_in = EXP_W'($urandom_range(248, 255));
            default: exp_in = EXP_W'($urandom);
        endcase
        ovf                = 1'($urandom);
        ovf_rnd            = 1'($urandom);
        one_shift_left     = 1'($urandom);
        massive_shift_left = ($urandom_range(0, 1) == 0) ? '0 : SHL_W'($urandom);
        sum                = ($urandom_range(0, 5) == 0) ? '0 : SUM_W'($urandom);
        man_in             = MAN_W'($urandom);
    endtask

    task automatic clear_queues();
        pend_q.delete();
        obs_q.delete();
        ref_q.delete();
        spurious = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_in = '0; ovf = 1'b0; ovf_rnd = 1'b0; one_shift_left = 1'b0;
        massive_shift_left = '0; sum = '0; man_in = '0;
`ifdef EXP_UPD_STICKY_EN
        clr_sticky = 1'b0; m_sov = 1'b0; m_sunf = 1'b0;
`endif
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        vectors++;
        if (cur_out() !== res_t'(0)) begin
            miscompares++; $display("FAIL reset_fields got %h want 0", cur_out());
        end
`ifdef EXP_UPD_STICKY_EN
        vectors++;
        if ({sticky_ovf, sticky_unf} !== 2'b00) begin
            miscompares++; $display("FAIL reset_sticky got %b want 00", {sticky_ovf, sticky_unf});
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        clear_queues();
    endtask

    task automatic test_directed();
        dvec_t tbl[10];
        res_t  want;
        tbl = '{
            '{100, 1, 0, 0,  0, 'h123, 'hC00001, 101,  'hC00001, 0, 0, 0, 0},
            '{254, 1, 1, 0,  0,     1, 'hFFFFFF, 255,        0, 1, 0, 0, 0},
            '{  3, 0, 0, 0,  5,  'h40, 'h800000,   0, 'h800000, 0, 0, 1, 3},
            '{200, 0, 0, 0,  0,     0, 'h912345,   0, 'h912345, 0, 1, 0, 0},
            '{254, 1, 0, 0,  0,     5, 'hA00000, 255,        0, 1, 0, 0, 0},
            '{254, 0, 0, 0,  0,     5, 'hA00001, 254, 'hA00001, 0, 0, 0, 0},
            '{  1, 0, 0, 1,  0,     7, 'hB00000,   0, 'hB00000, 0, 0, 1, 1},
            '{  1, 1, 0, 1,  0,     7, 'hB00001,   1, 'hB00001, 0, 0, 0, 0},
            '{  0, 0, 0, 1, 31,     9, 'hC00000,   0, 'hC00000, 0, 0, 1, 33},
            '{255, 1, 1, 0,  0,     0, 'h777777,   0, 'h777777, 0, 1, 0, 0}
        };
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_in = EXP_W'(tbl[i].ei); ovf = tbl[i].o[0]; ovf_rnd = tbl[i].r[0];
            one_shift_left = tbl[i].s[0]; massive_shift_left = SHL_W'(tbl[i].m);
            sum = SUM_W'(tbl[i].sm); man_in = MAN_W'(tbl[i].mn);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++; $display("FAIL dir%0d_early_valid got %0b want 0", i, out_valid);
            end
            step();
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++; $display("FAIL dir%0d_latency got %0b want 1", i, out_valid);
            end
            want = mk_res(tbl[i]);
            vectors++;
            if (cur_out() !== want) begin
                miscompares++; $display("FAIL dir%0d_fields got %h want %h", i, cur_out(), want);
            end
            step();
        end
`ifdef EXP_UPD_STICKY_EN
        vectors++;
        if ({sticky_ovf, sticky_unf} !== 2'b11) begin
            miscompares++; $display("FAIL dir_sticky got %b want 11", {sticky_ovf, sticky_unf});
        end
`endif
        clear_queues();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_rand_inputs();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
`ifdef EXP_UPD_STICKY_EN
            clr_sticky = ($urandom_range(0, 19) == 0);
`endif
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
`ifdef EXP_UPD_STICKY_EN
        clr_sticky = 1'b0;
`endif
        repeat (4) step();
        vectors++;
        if (pend_q.size() != 0 || spurious != 0) begin
            miscompares++;
            $display("FAIL rand_count got pending=%0d extra=%0d want 0/0", pend_q.size(), spurious);
        end
        for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== ref_q[i]) begin
                miscompares++; $display("FAIL rand%0d got %h want %h", i, obs_q[i], ref_q[i]);
            end
        end
`ifdef EXP_UPD_STICKY_EN
        vectors++;
        if ({sticky_ovf, sticky_unf} !== {m_sov, m_sunf}) begin
            miscompares++;
            $display("FAIL rand_sticky got %b want %b", {sticky_ovf, sticky_unf}, {m_sov, m_sunf});
        end
`endif
        clear_queues();
    endtask

    task automatic test_backpressure();
        int   c;
        int   acc;
        res_t snap;
        c = 0; acc = 0; snap = '0;
        while (acc < 4 && c < 40) begin
            out_ready = (c >= 5);
            set_rand_inputs();
            in_valid = 1'b1;
            step();
            if (last_acc) acc++;
            if (c == 1) snap = cur_out();
            if (c >= 2 && c <= 4) begin
                vectors++;
                if (out_valid !== 1'b1 || cur_out() !== snap) begin
                    miscompares++;
                    $display("FAIL bp_hold%0d got %0b/%h want 1/%h", c, out_valid, cur_out(), snap);
                end
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++; $display("FAIL bp_in_ready%0d got %0b want 0", c, in_ready);
                end
            end
            c++;
        end
        if (acc < 4) begin
            vectors++; miscompares++;
            $display("FAIL bp_timeout got %0d accepted want 4", acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();
        vectors++;
        if (obs_q.size() != 4 || spurious != 0) begin
            miscompares++; $display("FAIL bp_count got %0d want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== ref_q[i]) begin
                miscompares++; $display("FAIL bp_order%0d got %h want %h", i, obs_q[i], ref_q[i]);
            end
        end
        clear_queues();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_rand_inputs(); in_valid = 1'b1; step();
        set_rand_inputs(); step();
        set_rand_inputs(); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_valid got %0b want 0", out_valid);
        end
        out_ready = 1'b1;
        repeat (4) step();
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++; $display("FAIL flush_outputs got %0d want 0", obs_q.size());
        end
        set_rand_inputs(); in_valid = 1'b1; step();
        in_valid = 1'b0;
        repeat (3) step();
        vectors++;
        if (obs_q.size() != 1 || obs_q[0] !== ref_q[0]) begin
            miscompares++;
            $display("FAIL flush_resume got %0d outputs want 1 matching", obs_q.size());
        end
        clear_queues();
    endtask

`ifdef EXP_UPD_STICKY_EN
    task automatic test_sticky_clear();
        out_ready = 1'b1;
        exp_in = 8'd254; ovf = 1'b1; ovf_rnd = 1'b1; one_shift_left = 1'b0;
        massive_shift_left = '0; sum = 27'd1; man_in = 24'h123456;
        in_valid = 1'b1; step();
        in_valid = 1'b0; step();
        clr_sticky = 1'b1; step();
        vectors++;
        if (sticky_ovf !== 1'b1 || m_sov !== 1'b1) begin
            miscompares++; $display("FAIL sticky_set_wins got %0b want 1", sticky_ovf);
        end
        step();
        clr_sticky = 1'b0;
        vectors++;
        if ({sticky_ovf, sticky_unf} !== 2'b00) begin
            miscompares++; $display("FAIL sticky_clear got %b want 00", {sticky_ovf, sticky_unf});
        end
        clear_queues();
    endtask
`endif

    task automatic test_rst_mid();
        out_ready = 1'b1;
        exp_in = 8'd254; ovf = 1'b1; ovf_rnd = 1'b1; one_shift_left = 1'b0;
        massive_shift_left = '0; sum = 27'd3; man_in = 24'hABCDEF;
        in_valid = 1'b1; step();
        set_rand_inputs(); step();
        set_rand_inputs(); step();
`ifdef EXP_UPD_STICKY_EN
        vectors++;
        if (sticky_ovf !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre_sticky got %0b want 1", sticky_ovf);
        end
`endif
        clear_queues();
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || cur_out() !== res_t'(0)) begin
            miscompares++; $display("FAIL rst_async got %0b/%h want 0/0", out_valid, cur_out());
        end
`ifdef EXP_UPD_STICKY_EN
        m_sov = 1'b0; m_sunf = 1'b0;
        vectors++;
        if ({sticky_ovf, sticky_unf} !== 2'b00) begin
            miscompares++; $display("FAIL rst_sticky got %b want 00", {sticky_ovf, sticky_unf});
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        repeat (5) step();
        vectors++;
        if (obs_q.size() != 0 || spurious != 0) begin
            miscompares++; $display("FAIL rst_dropped got %0d outputs want 0", obs_q.size());
        end
        clear_queues();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        spurious    = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
`ifdef EXP_UPD_STICKY_EN
        test_sticky_clear();
`endif
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exp_update_pipe.md
EXP_UPDATE_PIPE -- requirements
Module: exp_update_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter EXP_W, default 8, SHALL be the biased exponent width.
REQ-003 Parameter MAN_W, default 24, SHALL be the mantissa width including the hidden bit.
REQ-004 Parameter SUM_W, default MAN_W+3, SHALL be the adder sum width including guard, round and sticky bits.
REQ-005 Parameter SHL_W, default 5, SHALL be the massive-left-shift count width.
REQ-006 Derived constant EXT_W SHALL equal EXP_W+2, a signed internal exponent width.
REQ-007 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-008 Port rst, input, 1: asynchronous active-high reset.
REQ-009 Port flush, input, 1: synchronous pipeline clear.
REQ-010 Port in_valid, input, 1 and port in_ready, output, 1: upstream handshake.
REQ-011 Port exp_in, input, EXP_W: selected larger exponent.
REQ-012 Ports ovf, ovf_rnd and one_shift_left, input, 1 each: normalisation and rounding adjustments.
REQ-013 Port massive_shift_left, input, SHL_W: leading-zero shift count.
REQ-014 Port sum, input, SUM_W and port man_in, input, MAN_W: adder sum and rounded mantissa.
REQ-015 Port out_valid, output, 1 and port out_ready, input, 1: downstream handshake.
REQ-016 Port exp_out, output, EXP_W and port man_out, output, MAN_W: result fields.
REQ-017 Ports max_exp_flag, zero_flag and underflow_flag, output, 1 each: classification flags.
REQ-018 Port excess_shift, output, EXT_W: denormalisation right-shift amount.

Function
REQ-019 Stage 1 SHALL register the signed value e = exp_in + ovf + ovf_rnd - one_shift_left - massive_shift_left at EXT_W bits, without overflow, together with sum and man_in.
REQ-020 Stage 2 SHALL classify from the registered values in this priority order: zero, overflow, underflow, normal.
REQ-021 Zero: when sum == 0, the block SHALL set zero_flag=1, exp_out=0 and excess_shift=0, and all other flags SHALL be 0.
REQ-022 Overflow: when e >= 2^EXP_W-1, the block SHALL set exp_out to all ones, max_exp_flag=1 and man_out=0.
REQ-023 Underflow: when e <= 0, the block SHALL set exp_out=0, underflow_flag=1 and excess_shift=1-e.
REQ-024 Normal: otherwise the block SHALL set exp_out=e[EXP_W-1:0], all flags 0 and excess_shift=0.
REQ-025 Outside the overflow case, man_out SHALL equal man_in delayed through the pipeline.
REQ-026 Latency SHALL be 2 cycles from an accepted input to out_valid when out_ready is held at 1.
REQ-027 Throughput SHALL be one transfer per cycle.
REQ-028 An input SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-029 Each stage SHALL advance only when it is empty or its contents are moving forward in that cycle.
REQ-030 in_ready SHALL equal !s1_valid OR s1_advance.
REQ-031 While out_valid=1 and out_ready=0, all outputs SHALL hold stable and no data SHALL be lost or duplicated.
REQ-032 When flush=1, both stage valids SHALL clear on the next edge.
REQ-033 The input presented in the same cycle as flush SHALL be discarded; flush SHALL take priority over acceptance.

Reset
REQ-034 While rst=1, all stage valids SHALL be 0 and out_valid SHALL be 0.
REQ-035 While rst=1, exp_out, man_out, excess_shift and all flags SHALL be 0.
REQ-036 An assertion of rst in the middle of a transfer SHALL drop any in-flight data with no partial output.

Configuration
REQ-037 With macro EXP_UPD_STICKY_EN defined, the block SHALL add input clr_sticky and outputs sticky_ovf and sticky_unf.
REQ-038 sticky_ovf and sticky_unf SHALL set on each out_valid AND out_ready transfer carrying the corresponding flag.
REQ-039 clr_sticky SHALL clear both sticky bits; a set occurring in the same cycle as clr_sticky SHALL win.
REQ-040 rst SHALL clear both sticky bits.
REQ-041 With EXP_UPD_STICKY_EN undefined, those ports and registers SHALL be absent.

Structure
REQ-042 Package fpu_pkg SHALL hold the EXP_W/MAN_W defaults, EXT_W derivation, bias constant and the classification enum {ZERO, OVF, UNF, NORM}.
REQ-043 One sub-module, exp_classify, SHALL hold the combinational stage-2 classification logic.

Verification
REQ-044 Normal case: exp_in=100, ovf=1, other adjustments 0, sum nonzero -> after 2 cycles exp_out=101 with all flags 0.
REQ-045 Overflow case: exp_in=254, ovf=1, ovf_rnd=1 -> exp_out=255, max_exp_flag=1, man_out=0.
REQ-046 Underflow case: exp_in=3, massive_shift_left=5 -> e=-2, exp_out=0, underflow_flag=1, excess_shift=3.
REQ-047 Zero case: sum=0 with exp_in=200 -> zero_flag=1, exp_out=0.
REQ-048 Backpressure: stream 4 inputs, hold out_ready=0 for 3 cycles, then release -> 4 outputs appear in order with none lost; in_ready=0 while both stages are full.
REQ-049 Flush and reset: flush with 2 transfers in flight -> no outputs; rst mid-stream -> out_valid=0 immediately, and the sticky bits clear when EXP_UPD_STICKY_EN is defined.
